// File: rtl/bin_cnt_prog_if.sv
// Control, value and status bundle of the programmable binary counter.
// The master side drives controls and values; the counter is the slave.
interface bin_cnt_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             clr;
    logic             start;
    logic             stop;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] n_start;
    logic [WIDTH-1:0] n_count;
    logic [WIDTH-1:0] count;
    logic             max_tick;
    logic             busy;
    logic             done;

    modport master (
        output en, clr, start, stop, mode, dir, n_start, n_count,
        input  count, max_tick, busy, done
    );

    modport slave (
        input  en, clr, start, stop, mode, dir, n_start, n_count,
        output count, max_tick, busy, done
    );
endinterface

// File: rtl/bin_cnt_prog.sv
// Programmable up/down binary counter with free-run / one-shot modes and an
// IDLE/RUN/DONE control FSM; used as a tick generator and interval timer.
module bin_cnt_prog #(
    parameter int          WIDTH      = 8,
    parameter int unsigned INIT       = 1,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    bin_cnt_prog_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT);
    localparam state_e           RST_STATE = AUTO_START ? ST_RUN : ST_IDLE;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             at_term_s;

    assign at_term_s = (count_q == bus.n_count);

    // Next state: clr > stop > start > count step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        if (bus.clr) begin
            count_d = bus.n_start;
            done_d  = 1'b0;
            state_d = RST_STATE;
        end else if (bus.stop) begin
            // stop also masks a simultaneous start, whatever the state
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_q;
            end
        end else if (bus.start) begin
            count_d = bus.n_start;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.en) begin
                        count_d = count_q;
                    end else if (at_term_s) begin
                        if (bus.mode) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            count_d = bus.n_start;
                        end
                    end else if (bus.dir) begin
                        count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, count and done registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST_STATE;
            count_q <= INIT_V;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q == ST_RUN);
    assign bus.max_tick = (state_q == ST_RUN) & bus.en & at_term_s;

endmodule

// File: tb/tb_bin_cnt_prog.sv
// Bench for bin_cnt_prog: one AUTO_START=1 and one AUTO_START=0 instance share
// stimulus; a cycle model, a vector table and directed sequences check them.
module tb_bin_cnt_prog;
    localparam int M      = 256;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, clr, start, stop, mode, dir;
    logic [7:0] ns, nc;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt[2];
    int m_st[2];
    bit m_dne[2];
    int auto_st[2] = '{S_RUN, S_IDLE};

    typedef struct {
        logic       clr, stop, start, en, mode, dir;
        logic [7:0] ns, nc;
        logic [7:0] c;
        logic       t, b, d;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;

    bin_cnt_prog_if #(.WIDTH(8)) ifa ();
    bin_cnt_prog_if #(.WIDTH(8)) ifb ();

    assign ifa.en = en;   assign ifb.en = en;
    assign ifa.clr = clr; assign ifb.clr = clr;
    assign ifa.start = start; assign ifb.start = start;
    assign ifa.stop = stop;   assign ifb.stop = stop;
    assign ifa.mode = mode;   assign ifb.mode = mode;
    assign ifa.dir = dir;     assign ifb.dir = dir;
    assign ifa.n_start = ns;  assign ifb.n_start = ns;
    assign ifa.n_count = nc;  assign ifb.n_count = nc;

    bin_cnt_prog #(.WIDTH(8), .INIT(1), .AUTO_START(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    bin_cnt_prog #(.WIDTH(8), .INIT(1), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic read_out(input int k, output logic [7:0] c, output logic t, output logic b,
                            output logic d);
        if (k == 0) begin
            c = ifa.count; t = ifa.max_tick; b = ifa.busy; d = ifa.done;
        end else begin
            c = ifb.count; t = ifb.max_tick; b = ifb.busy; d = ifb.done;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 1;
            m_st[k]  = auto_st[k];
            m_dne[k] = 1'b0;
        end
    endtask

    task automatic model_check();
        logic [7:0] c;
        logic t, b, d;
        for (int k = 0; k < 2; k++) begin
            read_out(k, c, t, b, d);
            check(k == 0 ? "mdl_count_a" : "mdl_count_b", 32'(c), 32'(m_cnt[k]));
            check(k == 0 ? "mdl_tick_a" : "mdl_tick_b", 32'(t),
                  32'(m_st[k] == S_RUN && en && m_cnt[k] == int'(nc)));
            check(k == 0 ? "mdl_busy_a" : "mdl_busy_b", 32'(b), 32'(m_st[k] == S_RUN));
            check(k == 0 ? "mdl_done_a" : "mdl_done_b", 32'(d), 32'(m_dne[k]));
        end
    endtask

    // What the counter should do on this clock edge, given the current inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_cnt[k] = int'(ns); m_dne[k] = 1'b0; m_st[k] = auto_st[k];
            end else if (stop) begin
                if (m_st[k] == S_RUN) m_st[k] = S_IDLE;
            end else if (start) begin
                m_cnt[k] = int'(ns); m_dne[k] = 1'b0; m_st[k] = S_RUN;
            end else if (m_st[k] == S_RUN && en) begin
                if (m_cnt[k] == int'(nc)) begin
                    if (!mode) m_cnt[k] = int'(ns);
                    else begin m_st[k] = S_DONE; m_dne[k] = 1'b1; end
                end else begin
                    m_cnt[k] = dir ? (m_cnt[k] + M - 1) % M : (m_cnt[k] + 1) % M;
                end
            end
        end
    endtask

    task automatic pre();
        #1;
        model_check();
    endtask

    task automatic post();
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    task automatic idle();
        clr = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    initial begin
        int tick_n, first_tick, gap;
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd2, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd3, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        idle();
        en = 1'b1; mode = 1'b0; dir = 1'b0; ns = 8'd1; nc = 8'd5;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_count_a", 32'(ifa.count), 32'd1);
        check("rst_busy_a", 32'(ifa.busy), 32'd1);
        check("rst_busy_b", 32'(ifb.busy), 32'd0);
        check("rst_done_b", 32'(ifb.done), 32'd0);
        reset = 1'b1;

        // Free run from reset: 1..5 repeating, tick on 5.
        for (int i = 0; i < 10; i++) begin
            pre();
            check("free_count", 32'(ifa.count), 32'((i % 5) + 1));
            check("free_tick", 32'(ifa.max_tick), 32'((i % 5) == 4));
            post();
        end

        // Down count wrapping through 0.
        ns = 8'd2; nc = 8'd254; dir = 1'b1; start = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 10; i++) begin
            int s;
            s = 2 - (i % 5);
            if (s < 0) s = s + M;
            pre();
            check("down_count", 32'(ifa.count), 32'(s));
            check("down_tick", 32'(ifa.max_tick), 32'((i % 5) == 4));
            post();
        end

        // One-shot from the vector table on the AUTO_START=0 instance.
        clr = 1'b1; ns = 8'd0; nc = 8'd3; mode = 1'b1; dir = 1'b0;
        cyc();
        for (int i = 0; i < 11; i++) begin
            clr = tbl[i].clr; stop = tbl[i].stop; start = tbl[i].start; en = tbl[i].en;
            mode = tbl[i].mode; dir = tbl[i].dir; ns = tbl[i].ns; nc = tbl[i].nc;
            pre();
            check("tbl_count", 32'(ifb.count), 32'(tbl[i].c));
            check("tbl_tick", 32'(ifb.max_tick), 32'(tbl[i].t));
            check("tbl_busy", 32'(ifb.busy), 32'(tbl[i].b));
            check("tbl_done", 32'(ifb.done), 32'(tbl[i].d));
            post();
        end

        // Enable toggled every other cycle: period doubles to 8 clocks.
        idle();
        ns = 8'd1; nc = 8'd4; mode = 1'b0; dir = 1'b0; en = 1'b1; start = 1'b1;
        cyc();
        idle();
        tick_n = 0; first_tick = -1; gap = -1;
        for (int i = 0; i < 16; i++) begin
            en = ((i % 2) == 0);
            pre();
            if (ifa.max_tick === 1'b1) begin
                tick_n++;
                if (first_tick < 0) first_tick = i; else gap = i - first_tick;
            end
            post();
        end
        check("en_tick_count", 32'(tick_n), 32'd2);
        check("en_period", 32'(gap), 32'd8);
        en = 1'b1;
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        idle();
        pre();
        check("stop_count", 32'(ifa.count), 32'd3);
        check("stop_busy", 32'(ifa.busy), 32'd0);
        post();

        // Priority: clr+stop+start, then start+stop.
        start = 1'b1;
        cyc();
        idle();
        cyc();
        cyc();
        clr = 1'b1; stop = 1'b1; start = 1'b1; ns = 8'd9;
        cyc();
        idle();
        en = 1'b0;
        pre();
        check("prio_clr_count", 32'(ifb.count), 32'd9);
        check("prio_clr_busy", 32'(ifb.busy), 32'd0);
        check("prio_clr_auto", 32'(ifa.busy), 32'd1);
        post();
        ns = 8'd1; start = 1'b1; en = 1'b1;
        cyc();
        idle();
        cyc();
        cyc();
        start = 1'b1; stop = 1'b1; ns = 8'd20;
        cyc();
        idle();
        pre();
        check("prio_ss_count", 32'(ifb.count), 32'd3);
        check("prio_ss_busy", 32'(ifb.busy), 32'd0);
        post();

        // n_start == n_count: tick every enabled cycle.
        ns = 8'd7; nc = 8'd7; start = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 6; i++) begin
            pre();
            check("eq_count", 32'(ifa.count), 32'd7);
            check("eq_tick", 32'(ifa.max_tick), 32'd1);
            post();
        end

        // Asynchronous reset in the middle of a count.
        ns = 8'd1; nc = 8'd9; start = 1'b1;
        cyc();
        idle();
        cyc();
        cyc();
        pre();
        check("arst_before", 32'(ifa.count), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("arst_count_a", 32'(ifa.count), 32'd1);
        check("arst_count_b", 32'(ifb.count), 32'd1);
        check("arst_busy_a", 32'(ifa.busy), 32'd1);
        check("arst_busy_b", 32'(ifb.busy), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            clr   = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 29) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                mode = ($urandom_range(0, 3) == 0);
                dir  = 1'($urandom_range(0, 1));
                ns   = 8'($urandom_range(0, 255));
                nc   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                   : ns + 8'($urandom_range(0, 12));
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
